// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus burst controller.
package rtc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD,
        NEXT,
        DONE
    } state_e;

    // Register window: time, date, then timer registers
    localparam int IDX_SEG   = 0;
    localparam int IDX_MIN   = 1;
    localparam int IDX_HORA  = 2;
    localparam int IDX_DIA   = 3;
    localparam int IDX_MES   = 4;
    localparam int IDX_ANO   = 5;
    localparam int IDX_TSEG  = 6;
    localparam int IDX_TMIN  = 7;
    localparam int IDX_THORA = 8;

    localparam logic [7:0] DEF_BASE_ADDR = 8'h21;
    localparam int         DEF_T_GAP     = 2;
    localparam int         DEF_T_PHASE   = 4;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by all timed FSM states; o_zero marks the last cycle of a phase.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero,
    output logic         o_zero_nxt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    // Lets the owner register outputs that depend on the coming cycle being the last one
    assign o_zero_nxt = i_load ? (i_load_val == '0) : (r_cnt <= W'(1));

endmodule

// File: rtl/rtc_bus_burst_ctrl.sv
// Burst master for the RTC chip's multiplexed address/data bus with auto-incrementing window index.
module rtc_bus_burst_ctrl
    import rtc_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 N_REGS    = 9,
    parameter logic [DATA_W-1:0]  BASE_ADDR = DATA_W'(rtc_pkg::DEF_BASE_ADDR),
    parameter int                 T_GAP     = rtc_pkg::DEF_T_GAP,
    parameter int                 T_PHASE   = rtc_pkg::DEF_T_PHASE,
    localparam int                IW        = $clog2(N_REGS)
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     start,
    input  logic                     rw,
    input  logic [IW-1:0]            first,
    input  logic [IW:0]              count,
    input  logic [N_REGS*DATA_W-1:0] wr_data,
    output logic [N_REGS*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     CSO,
    output logic                     ADO,
    output logic                     RDO,
    output logic                     WRO,
    inout  wire  [DATA_W-1:0]        Bus_Dato_Dir
);

    localparam int TMAX = (T_GAP > T_PHASE) ? T_GAP : T_PHASE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] GAP_L   = TW'(T_GAP - 1);
    localparam logic [TW-1:0] PHASE_L = TW'(T_PHASE - 1);

    state_e                     r_state, w_state_nxt;
    logic   [IW-1:0]            r_idx, w_idx_inc, w_idx_sel;
    logic   [IW:0]              r_rem;
    logic                       r_rw;
    logic   [DATA_W-1:0]        r_dout;
    logic                       r_oe, r_cso, r_ado, r_rdo, r_wro, r_busy, r_done;
    logic   [N_REGS*DATA_W-1:0] r_rd_data;
    logic                       w_load, w_zero, w_zero_nxt, w_capture;
    logic   [TW-1:0]            w_load_val;
    logic                       w_a_ph, w_d_ph;

    phase_timer #(.W(TW)) u_timer (
        .i_clk      (CLK),
        .i_rst_n    (Reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero),
        .o_zero_nxt (w_zero_nxt)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = GAP_L;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_state_nxt = A_SET;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            A_SET: if (w_zero) begin w_state_nxt = A_STB; w_load = 1'b1; w_load_val = PHASE_L; end
            A_STB: if (w_zero) begin w_state_nxt = A_HLD; w_load = 1'b1; end
            A_HLD: if (w_zero) begin w_state_nxt = D_SET; w_load = 1'b1; end
            D_SET: if (w_zero) begin w_state_nxt = D_STB; w_load = 1'b1; w_load_val = PHASE_L; end
            D_STB: if (w_zero) begin w_state_nxt = D_HLD; w_load = 1'b1; end
            D_HLD: if (w_zero) w_state_nxt = NEXT;
            NEXT: begin
                if (r_rem > (IW+1)'(1)) begin
                    w_state_nxt = A_SET;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_idx_inc = (r_idx == IW'(N_REGS - 1)) ? '0 : r_idx + 1'b1;
    assign w_idx_sel = (r_state == IDLE) ? first : w_idx_inc;
    assign w_capture = (r_state == D_STB) && w_zero && !r_rw;
    assign w_a_ph    = (w_state_nxt == A_SET) || (w_state_nxt == A_STB) || (w_state_nxt == A_HLD);
    assign w_d_ph    = (w_state_nxt == D_SET) || (w_state_nxt == D_STB) || (w_state_nxt == D_HLD);

    // Strobes and bus enable are decoded from the next state so every pin comes straight off a flop
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_idx  <= '0;
            r_rem  <= '0;
            r_rw   <= 1'b0;
            r_dout <= '0;
            r_oe   <= 1'b0;
            r_cso  <= 1'b1;
            r_ado  <= 1'b1;
            r_rdo  <= 1'b1;
            r_wro  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (r_state == IDLE && start && count != '0) begin
                r_rw  <= rw;
                r_idx <= first;
                r_rem <= count;
            end
            if (r_state == NEXT) begin
                r_rem <= r_rem - 1'b1;
                r_idx <= w_idx_inc;
            end
            if (w_load && w_state_nxt == A_SET) begin
                r_dout <= BASE_ADDR + DATA_W'(w_idx_sel);
            end
            if (w_load && w_state_nxt == D_SET) begin
                r_dout <= wr_data[r_idx*DATA_W +: DATA_W];
            end
            r_oe   <= w_a_ph || (w_d_ph && r_rw);
            r_cso  <= !((w_a_ph || w_d_ph) && !(w_state_nxt == D_HLD && w_zero_nxt));
            r_ado  <= !w_a_ph;
            r_wro  <= !((w_state_nxt == A_STB) || (w_state_nxt == D_STB && r_rw));
            r_rdo  <= !(w_state_nxt == D_STB && !r_rw);
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    // A reset that lands mid-burst leaves already captured words in place
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (!r_busy) r_rd_data <= '0;
        end else if (w_capture) begin
            r_rd_data[r_idx*DATA_W +: DATA_W] <= Bus_Dato_Dir;
        end
    end

    assign Bus_Dato_Dir = r_oe ? r_dout : {DATA_W{1'bz}};
    assign rd_data      = r_rd_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign CSO          = r_cso;
    assign ADO          = r_ado;
    assign RDO          = r_rdo;
    assign WRO          = r_wro;

endmodule

// File: tb/tb_rtc_bus_burst_ctrl.sv
// Bench for rtc_bus_burst_ctrl: directed table, reset/restart corners and random bursts against a timing model.
module tb_rtc_bus_burst_ctrl;

    localparam int DW = 8;
    localparam int N  = 9;
    localparam int IW = $clog2(N);
    localparam int G  = 2;
    localparam int P  = 4;
    localparam int WL = 4*G + 2*P + 1;
    localparam logic [7:0] BASE = 8'h21;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    logic start = 1'b0;
    logic rw = 1'b0;
    logic [IW-1:0]   first = '0;
    logic [IW:0]     count = '0;
    logic [N*DW-1:0] wr_data = '0;
    wire  [N*DW-1:0] rd_data;
    wire busy, done, CSO, ADO, RDO, WRO;
    tri1  [DW-1:0]   bus;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_rd   [N];
    logic [DW-1:0] chip_mem [N];
    logic [DW-1:0] chip_addr = '0;
    logic [DW-1:0] chip_off;
    logic [DW-1:0] chip_dout;

    rtc_bus_burst_ctrl #(
        .DATA_W(DW), .N_REGS(N), .BASE_ADDR(BASE), .T_GAP(G), .T_PHASE(P)
    ) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .rw(rw), .first(first), .count(count),
        .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
        .CSO(CSO), .ADO(ADO), .RDO(RDO), .WRO(WRO), .Bus_Dato_Dir(bus)
    );

    always #5 CLK = ~CLK;

    // Chip model: latches the address phase, answers reads while RDO is low
    always @(posedge CLK) if (!CSO && !ADO) chip_addr <= bus;
    always_comb begin
        chip_off  = chip_addr - BASE;
        chip_dout = '0;
        if (int'(chip_off) < N) chip_dout = chip_mem[chip_off];
    end
    assign bus = (!CSO && !RDO) ? chip_dout : {DW{1'bz}};

    typedef struct packed {
        logic cso, ado, rdo, wro, busy, done;
        logic [7:0] bus;
    } obs_t;

    typedef struct {
        bit              wr;
        int              f;
        int              c;
        logic [N*DW-1:0] wd;
        bit              scramble;
        bit              restart;
        int              exp_done;
        logic [7:0]      exp_addr0;
    } vec_t;

    function automatic logic [N*DW-1:0] pack_exp();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_rd[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected pins for cycle j after the start edge; an undriven bus reads as FF
    function automatic obs_t expect_at(int j, bit wr, int f, int c, logic [N*DW-1:0] wd);
        obs_t e;
        int w, o, idx;
        e = '{cso:1'b1, ado:1'b1, rdo:1'b1, wro:1'b1, busy:1'b0, done:1'b0, bus:8'hFF};
        if (j < c*WL) begin
            w = j / WL;
            o = j % WL;
            idx = (f + w) % N;
            e.busy = 1'b1;
            if (o < 4*G + 2*P - 1) e.cso = 1'b0;
            if (o < 2*G + P) begin
                e.ado = 1'b0;
                e.bus = BASE + 8'(idx);
            end
            if (o >= G && o < G + P) e.wro = 1'b0;
            if (o >= 2*G + P && o < 4*G + 2*P) begin
                if (wr) e.bus = wd[idx*DW +: DW];
                if (o >= 3*G + P && o < 3*G + 2*P) begin
                    if (wr) e.wro = 1'b0;
                    else begin
                        e.rdo = 1'b0;
                        e.bus = chip_mem[idx];
                    end
                end
            end
        end else if (j == c*WL) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic run_burst(input bit wr, input int f, input int c, input logic [N*DW-1:0] wd,
                             input bit scramble, input bit restart, input string tag,
                             output int done_at, output logic [7:0] addr0);
        int bad, L, o;
        obs_t a, e;
        string fmsg;
        bad = 0;
        fmsg = "";
        L = c * WL;
        done_at = -1;
        addr0 = 8'h00;
        @(negedge CLK);
        rw = wr; first = IW'(f); count = (IW+1)'(c); wr_data = wd; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; rw = ~wr; first = IW'((f + 3) % N); count = (IW+1)'((c + 2) % (N + 1));
        for (int j = 0; j <= L + 3; j++) begin
            if (j > 0) begin @(posedge CLK); #1; end
            a = '{cso:CSO, ado:ADO, rdo:RDO, wro:WRO, busy:busy, done:done, bus:bus};
            e = expect_at(j, wr, f, c, wd);
            if (a.done && done_at < 0) done_at = j + 1;
            if (j == 0) addr0 = bus;
            if (a !== e) begin
                if (bad == 0) fmsg = $sformatf("cycle=%0d actual=%0h required=%0h", j, a, e);
                bad++;
            end
            if (!a.rdo && !a.wro) begin
                if (bad == 0) fmsg = $sformatf("cycle=%0d RDO and WRO both low", j);
                bad++;
            end
            o = j % WL;
            if (scramble && j < L && o == 2*G + P) wr_data = ~wd;
            if (scramble && j < L && o == WL - 1) wr_data = wd;
            if (restart && ((j == 5 && j < L - 1) || j == L)) begin
                start = 1'b1; rw = ~wr; first = IW'((f + 1) % N); count = (IW+1)'(1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!wr) for (int w = 0; w < c; w++) exp_rd[(f + w) % N] = chip_mem[(f + w) % N];
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_trace bad_cycles=%0d required=0 first %s", tag, bad, fmsg);
        end
        chk({tag, "_rd_data"}, 128'(rd_data), 128'(pack_exp()));
    endtask

    vec_t vecs[6];
    int   dat;
    logic [7:0] a0;
    int   n_done;

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            chip_mem[i] = 8'h30 + 8'(i);
            exp_rd[i]   = 8'h00;
        end
        chip_mem[5] = 8'h23;

        vecs[0] = '{1'b1, 0, 3, 72'h08_10_00, 1'b0, 1'b0, 52, 8'h21};
        vecs[1] = '{1'b0, 5, 1, 72'h0,        1'b0, 1'b0, 18, 8'h26};
        vecs[2] = '{1'b0, 7, 4, 72'h0,        1'b0, 1'b0, 69, 8'h28};
        vecs[3] = '{1'b1, 0, 0, 72'h0,        1'b0, 1'b0, 1,  8'hFF};
        vecs[4] = '{1'b1, 2, 2, 72'h11_22_33_44_55_66_77_88_99, 1'b1, 1'b1, 35, 8'h23};
        vecs[5] = '{1'b0, 8, 9, 72'h0,        1'b0, 1'b1, 154, 8'h29};

        Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_strobes", 128'({CSO, ADO, RDO, WRO}), 128'(4'hF));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_bus_z", 128'(bus), 128'(8'hFF));
        chk("rst_rd_data", 128'(rd_data), 128'(0));
        @(negedge CLK);
        Reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].wr, vecs[v].f, vecs[v].c, vecs[v].wd, vecs[v].scramble,
                      vecs[v].restart, $sformatf("vec%0d", v), dat, a0);
            chk($sformatf("vec%0d_done_latency", v), 128'(dat), 128'(vecs[v].exp_done));
            chk($sformatf("vec%0d_addr0", v), 128'(a0), 128'(vecs[v].exp_addr0));
        end

        // Reset during D_STB of the second word of a three-word write
        @(negedge CLK);
        rw = 1'b1; first = '0; count = (IW+1)'(3); wr_data = 72'hA5_5A_C3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (WL + 3*G + P + 1) @(posedge CLK);
        #1;
        chk("midrst_pre_wro", 128'({CSO, ADO, WRO, busy}), 128'(4'b0101));
        chk("midrst_pre_bus", 128'(bus), 128'(8'h5A));
        Reset = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        chk("midrst_strobes", 128'({CSO, ADO, RDO, WRO}), 128'(4'hF));
        chk("midrst_bus_z", 128'(bus), 128'(8'hFF));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        n_done = 0;
        for (int j = 0; j < 60; j++) begin
            @(posedge CLK); #1;
            if (done || busy || !CSO) n_done++;
        end
        chk("midrst_no_activity", 128'(n_done), 128'(0));
        chk("midrst_rd_kept", 128'(rd_data), 128'(pack_exp()));
        run_burst(1'b0, 3, 2, 72'h0, 1'b0, 1'b0, "after_rst", dat, a0);
        chk("after_rst_done_latency", 128'(dat), 128'(2*WL + 1));

        for (int r = 0; r < 25; r++) begin
            bit wr_r;
            int f_r, c_r;
            logic [N*DW-1:0] wd_r;
            for (int i = 0; i < N; i++) chip_mem[i] = 8'($urandom);
            wr_r = 1'($urandom);
            f_r  = int'($urandom_range(0, N - 1));
            c_r  = int'($urandom_range(0, N));
            wd_r = {8'($urandom), 32'($urandom), 32'($urandom)};
            run_burst(wr_r, f_r, c_r, wd_r, 1'($urandom), 1'($urandom),
                      $sformatf("rnd%0d", r), dat, a0);
            chk($sformatf("rnd%0d_done_latency", r), 128'(dat), 128'(c_r*WL + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
